// File: rtl/shift_seq_if.sv
// Command handshake bundle between a command source and the shift sequencer.
interface shift_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_amt, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_amt, cmd_data, output cmd_ready);
endinterface

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving an 8-bit universal shift register (load / shift / rotate by N).
// Optional macro SHIFT_SEQ_CARRY_EN builds a carry register holding the last bit shifted out.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high, mode hold
// LOAD  | parallel load presented to the register for one cycle
// SHIFT | shifting one position per cycle until the counter expires
// DONE  | one-cycle completion pulse, register holds its final value
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_if.slave       cmd,
    input  logic [WIDTH-1:0] reg_q,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] data_in,
    output logic             shift_in_left,
    output logic             shift_in_right,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             carry_out
);
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt;

    assign cmd.cmd_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_LOAD;
            cnt     <= '0;
            mode    <= MODE_HOLD;
            data_in <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q    <= cmd.cmd_op;
                        cnt     <= cmd.cmd_amt;
                        data_in <= cmd.cmd_data;
                        case (cmd.cmd_op)
                            OP_LOAD: begin
                                state <= ST_LOAD;
                                mode  <= MODE_LOAD;
                                busy  <= 1'b1;
                            end
                            OP_SRL, OP_SRA, OP_ROR, OP_SLL, OP_ROL: begin
                                if (cmd.cmd_amt != '0) begin
                                    state <= ST_SHIFT;
                                    busy  <= 1'b1;
                                    mode  <= (cmd.cmd_op == OP_SLL || cmd.cmd_op == OP_ROL)
                                             ? MODE_LEFT : MODE_RIGHT;
                                end else begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end
                            end
                            default: begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    state <= ST_DONE;
                    mode  <= MODE_HOLD;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                        mode  <= MODE_HOLD;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    mode  <= MODE_HOLD;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Fill bits follow the live register so rotates and sign extension track each step.
    always_comb begin
        shift_in_left  = 1'b0;
        shift_in_right = 1'b0;
        if (state == ST_SHIFT) begin
            case (op_q)
                OP_SRA:  shift_in_left  = reg_q[WIDTH-1];
                OP_ROR:  shift_in_left  = reg_q[0];
                OP_ROL:  shift_in_right = reg_q[WIDTH-1];
                default: begin
                    shift_in_left  = 1'b0;
                    shift_in_right = 1'b0;
                end
            endcase
        end
    end

`ifdef SHIFT_SEQ_CARRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_out <= 1'b0;
        end else if (state == ST_IDLE && cmd.cmd_valid) begin
            carry_out <= 1'b0;
        end else if (state == ST_SHIFT) begin
            carry_out <= (mode == MODE_RIGHT) ? reg_q[0] : reg_q[WIDTH-1];
        end
    end
`else
    assign carry_out = 1'b0;
`endif
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: drives a behavioural shift register and checks directed plus random commands.
module tb_shift_seq_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] reg_q = 8'h00;
    logic [1:0] mode;
    logic [7:0] data_in;
    logic       shift_in_left, shift_in_right, busy, done, err, carry_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] cur = 8'h00;

    shift_seq_if #(.WIDTH(8), .CNT_W(4)) cmd_if ();

    shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .cmd(cmd_if), .reg_q(reg_q),
        .mode(mode), .data_in(data_in),
        .shift_in_left(shift_in_left), .shift_in_right(shift_in_right),
        .busy(busy), .done(done), .err(err), .carry_out(carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The external universal shift register the sequencer drives.
    always @(posedge clk) begin
        case (mode)
            2'b01:   reg_q <= {shift_in_left, reg_q[7:1]};
            2'b10:   reg_q <= {reg_q[6:0], shift_in_right};
            2'b11:   reg_q <= data_in;
            default: reg_q <= reg_q;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {carry, value}: the arithmetic result of a whole command on start value v.
    function automatic logic [8:0] ref_model(input logic [2:0] op, input int amt,
                                             input logic [7:0] v, input logic [7:0] d);
        logic [7:0]  val;
        logic        cy;
        logic [15:0] t;
        int          r;
        val = v;
        cy  = 1'b0;
        r   = amt % 8;
        case (op)
            3'd0: val = d;
            3'd1: begin
                val = (amt >= 8) ? 8'h00 : (v >> amt);
                if (amt > 0 && amt <= 8) cy = v[amt-1];
            end
            3'd2: begin
                val = (amt >= 8) ? 8'h00 : (v << amt);
                if (amt > 0 && amt <= 8) cy = v[8-amt];
            end
            3'd3: begin
                val = (amt >= 8) ? {8{v[7]}} : 8'($signed(v) >>> amt);
                if (amt > 0) cy = v[(amt - 1 > 7) ? 7 : amt - 1];
            end
            3'd4: begin
                t   = {v, v} >> r;
                val = t[7:0];
                if (amt > 0) cy = v[(amt - 1) % 8];
            end
            3'd5: begin
                t   = {v, v} << r;
                val = t[15:8];
                if (amt > 0) cy = v[(8 - r) % 8];
            end
            default: val = v;
        endcase
        return {cy, val};
    endfunction

    // Issues one command from a negedge and checks timing, outputs and resulting register value.
    task automatic run_cmd(input logic [2:0] op, input int amt, input logic [7:0] d);
        logic [8:0] res;
        logic [1:0] exp_mode;
        logic       is_shift, exp_cy, fl, fr;
        int ed, done_cyc, n;
        int mode_bad, ready_bad, busy_bad, fill_bad;
        res      = ref_model(op, amt, cur, d);
        is_shift = (op >= 3'd1 && op <= 3'd5);
        exp_mode = (op == 3'd0) ? 2'b11 : (op == 3'd2 || op == 3'd5) ? 2'b10 : 2'b01;
        ed       = (op == 3'd0) ? 2 : (is_shift && amt > 0) ? amt + 1 : 1;
`ifdef SHIFT_SEQ_CARRY_EN
        exp_cy = res[8];
`else
        exp_cy = 1'b0;
`endif
        n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_amt   = 4'(amt);
        cmd_if.cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'($urandom);
        cmd_if.cmd_amt   = 4'($urandom);
        cmd_if.cmd_data  = 8'($urandom);
        done_cyc = 0;
        mode_bad = 0; ready_bad = 0; busy_bad = 0; fill_bad = 0;
        for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
            @(negedge clk);
            if (k % 3 == 0) cmd_if.cmd_valid = 1'b1;
            if (cmd_if.cmd_ready !== 1'b0) ready_bad++;
            fl = (k < ed && op == 3'd3) ? reg_q[7] : (k < ed && op == 3'd4) ? reg_q[0] : 1'b0;
            fr = (k < ed && op == 3'd5) ? reg_q[7] : 1'b0;
            if (shift_in_left !== fl || shift_in_right !== fr) fill_bad++;
            if (done === 1'b1) begin
                done_cyc = k;
                check("done_mode", mode, 0);
                check("done_busy", busy, 0);
                check("done_err", err, (op >= 3'd6) ? 1 : 0);
                check("result", reg_q, res[7:0]);
                check("carry", carry_out, exp_cy);
            end else begin
                if (mode !== exp_mode) mode_bad++;
                if (busy !== 1'b1) busy_bad++;
            end
        end
        cmd_if.cmd_valid = 1'b0;
        check("done_cycle", done_cyc, ed);
        check("mode_seq", mode_bad, 0);
        check("ready_low", ready_bad, 0);
        check("busy_seq", busy_bad, 0);
        check("fill_bits", fill_bad, 0);
        @(negedge clk);
        check("idle_ready", cmd_if.cmd_ready, 1);
        check("idle_done", done, 0);
        cur = res[7:0];
    endtask

    initial begin
        int quiet;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd0;
        cmd_if.cmd_amt   = 4'd0;
        cmd_if.cmd_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_data_in", data_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_carry", carry_out, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);
        check("rst_fills", {shift_in_left, shift_in_right}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(3'd0, 0, 8'hA5);
        check("load_a5", reg_q, 8'hA5);
        run_cmd(3'd0, 0, 8'h96);
        run_cmd(3'd3, 3, 8'h00);
        check("sra_f2", reg_q, 8'hF2);
        run_cmd(3'd0, 0, 8'hA5);
        run_cmd(3'd5, 4, 8'h00);
        check("rol_5a", reg_q, 8'h5A);
        run_cmd(3'd0, 0, 8'hFF);
        run_cmd(3'd2, 9, 8'h00);
        check("sll9_zero", reg_q, 8'h00);
        run_cmd(3'd0, 0, 8'hFF);
        run_cmd(3'd1, 0, 8'h00);
        check("srl0_ff", reg_q, 8'hFF);

        // Illegal op with valid held high through DONE into IDLE.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd7;
        cmd_if.cmd_amt   = 4'd3;
        cmd_if.cmd_data  = 8'h11;
        @(negedge clk);
        check("ill_done", done, 1);
        check("ill_err", err, 1);
        check("ill_mode", mode, 0);
        check("ill_ready_low", cmd_if.cmd_ready, 0);
        @(negedge clk);
        check("ill_idle_ready", cmd_if.cmd_ready, 1);
        check("ill_idle_done", done, 0);
        check("ill_idle_mode", mode, 0);
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("ill_reg_kept", reg_q, 8'hFF);

        // Reset in the third shift cycle of SRL 8 on 0xFF.
        run_cmd(3'd0, 0, 8'hFF);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd1;
        cmd_if.cmd_amt   = 4'd8;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_mode", mode, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_mode", mode, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_if.cmd_ready, 1);
        check("abort_reg", reg_q, 8'h1F);
        quiet = 0;
        for (int k = 0; k < 10; k++) begin
            if (done !== 1'b0) quiet++;
            @(negedge clk);
        end
        check("abort_no_done", quiet, 0);
        cur = reg_q;
        run_cmd(3'd0, 0, 8'h3C);
        check("load_3c", reg_q, 8'h3C);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(0, 7));
            if (i % 4 == 0) rop = 3'd0;
            run_cmd(rop, int'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
